comparador_seq: RTL
===================

# comparador_seq

Sequential equality checker for WIDTH-bit operands built around the existing 2-bit equality cell. The block serialises the comparison two bits per clock, LSB pair first, and stops early on the first mismatching pair. It sits between a requester issuing start/operand pulses and the shared comparador2bits datapath, and reports the result with a done pulse, a sticky equal flag and the index of the first differing pair.

## Interface
- WIDTH, 8, operand width in bits; even, ≥ 2.
- N (localparam), WIDTH/2, number of 2-bit pairs.
- PW (localparam), max(1, clog2(N)), width of pos.

- clk  in  1  single clock, all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand A; sampled on the accepting edge only.
- b  in  WIDTH  operand B; sampled on the accepting edge only.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse, result valid.
- igual  out  1  1 = operands equal; held until next accepted start.
- pos  out  PW  index of first mismatching pair when igual=0; 0 when igual=1; held until next accepted start.

## Operation
- States: IDLE, COMP, DONE.
- IDLE: start=1 → load a, b into shift registers sa, sb; idx ← 0; igual ← 0; pos ← 0; → COMP. start=0 → stay.
- COMP: sa[1:0], sb[1:0] drive the comparador2bits instance (y = pair equal).
  - y=0 → igual ← 0, pos ← idx, → DONE.
  - y=1, idx = N−1 → igual ← 1, pos ← 0, → DONE.
  - y=1, idx < N−1 → sa, sb shift right by 2, idx ← idx+1, stay.
- DONE: done=1 for this state only; → IDLE unconditionally.
- start in COMP or DONE is ignored (no queuing); changes on a/b after acceptance have no effect.
- Reset (rst_n=0 on an edge), from any state incl. mid-COMP: state ← IDLE, busy=0, done=0, igual=0, pos=0, sa=sb=0, idx=0; aborted operation produces no done.
- Reset value of every output: 0.

## Timing
- Accepting edge k (IDLE, start=1): busy=1 from edge k.
- Pair i evaluated on edge k+1+i.
- Full match: DONE entered at edge k+N; done high in the cycle after edge k+N; IDLE at edge k+N+1.
- Mismatch at pair i: DONE entered at edge k+i+1.
- Latency start-accept → done: N cycles (match), i+1 cycles (mismatch at pair i).
- igual/pos update on the same edge done rises; stable while done=1 and after.
- start held high continuously: new operation accepted on the edge where state is IDLE, i.e. period = latency+2 cycles.
- WIDTH=2: N=1, single COMP cycle, pos constant 0.

## Structure
- Shared package comparador_pkg: state encoding localparams (IDLE=2'b00, COMP=2'b01, DONE=2'b10) and the pair-count/PW helper function, reused by future wider or multi-requester comparator controllers.
- One sub-module: comparador2bits, instantiated once as the datapath; all sequencing (FSM, shift registers, idx counter, result registers) in comparador_seq.

## Test plan
- Reset: rst_n=0 for 2 edges with start=1, a=b=8'hFF → busy=done=igual=pos=0; no operation starts.
- Match: WIDTH=8, a=b=8'hA5, start 1 cycle → busy next cycle, done exactly 4 cycles after accepting edge, igual=1, pos=0, busy low 1 cycle later.
- Early mismatch: a=8'hA5, b=8'hA4 → done 1 cycle after accepting edge, igual=0, pos=0.
- Late mismatch + operand isolation: a=8'h35, b=8'hB5, change a to 8'h00 during COMP → done at 4 cycles, igual=0, pos=3.
- Back-to-back: start held high, a=b=8'h00 → done pulses every 6 cycles, igual=1; start during busy never shortens/restarts an operation.
- Reset mid-op: a=b=8'h3C, rst_n=0 on the second COMP edge → IDLE next cycle, no done, outputs 0; following start with a=b=8'h3C → done at 4 cycles, igual=1.

Source files
------------

// File: rtl/comparador_pkg.sv
// Shared definitions for the comparator controllers: state encoding and
// the helpers that size the pair index from the operand width.
package comparador_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'b00;
    localparam state_t COMP = 2'b01;
    localparam state_t DONE = 2'b10;

    function automatic int pair_count(input int width);
        return width / 2;
    endfunction

    // A single pair still needs a 1-bit index port.
    function automatic int pos_width(input int width);
        int n;
        n = width / 2;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/comparador_seq_if.sv
// Requester-side bundle of the sequential comparator: start/operands in,
// busy/done/result out, plus the controller state for observation.
interface comparador_seq_if #(parameter int WIDTH = 8);
    import comparador_pkg::*;

    localparam int PW = pos_width(WIDTH);

    // start is taken only while busy=0; a/b are captured on that same edge.
    // done pulses for one cycle, and igual/pos stay valid until the next accept.
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             igual;
    logic [PW-1:0]    pos;
    state_t           state;

    modport master (
        output start, a, b,
        input  busy, done, igual, pos, state
    );

    modport slave (
        input  start, a, b,
        output busy, done, igual, pos, state
    );

endinterface

// File: rtl/comparador2bits.sv
// 2-bit equality cell: y is high when both bit pairs match.
module comparador2bits (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       y
);

    assign y = &(a ~^ b);

endmodule

// File: rtl/comparador_seq.sv
// Serial equality checker: walks the operands two bits per clock, LSB pair
// first, and stops on the first differing pair.
module comparador_seq
    import comparador_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    comparador_seq_if.slave   bus
);

    localparam int N  = pair_count(WIDTH);
    localparam int PW = pos_width(WIDTH);
    localparam logic [PW-1:0] LAST_IDX = PW'(N - 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [PW-1:0]    idx;
    logic             igual_r;
    logic [PW-1:0]    pos_r;
    logic             pair_eq;
    logic             last_pair;

    comparador2bits u_cmp (
        .a (sa[1:0]),
        .b (sb[1:0]),
        .y (pair_eq)
    );

    assign last_pair = (idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = COMP;
            COMP:    if (!pair_eq || last_pair) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.busy  = (state != IDLE);
        bus.done  = (state == DONE);
        bus.state = state;
    end

    // Operands are captured once; later changes on a/b are never seen.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sa      <= '0;
            sb      <= '0;
            idx     <= '0;
            igual_r <= 1'b0;
            pos_r   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sa      <= bus.a;
                        sb      <= bus.b;
                        idx     <= '0;
                        igual_r <= 1'b0;
                        pos_r   <= '0;
                    end
                end
                COMP: begin
                    if (!pair_eq) begin
                        igual_r <= 1'b0;
                        pos_r   <= idx;
                    end else if (last_pair) begin
                        igual_r <= 1'b1;
                        pos_r   <= '0;
                    end else begin
                        sa  <= sa >> 2;
                        sb  <= sb >> 2;
                        idx <= idx + PW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.igual = igual_r;
    assign bus.pos   = pos_r;

endmodule
